ibuf_responder: RTL and testbench
=================================

IBUF_RESPONDER -- requirements
Module: ibuf_responder

Interface
REQ-001 SHALL have parameters: POY, default 3, number of banks; NROW, default 4, rows per bank; NCOL, default 16, columns per row; DW, default 8, pixel width in bits.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe
- wr_rdy  out  1  write accepted this cycle when high with wr_en
- wr_bank  in  2  write bank
- wr_row  in  2  write row
- wr_col  in  28  write column
- wr_data  in  DW  write pixel
- blkend  out  1  one-cycle pulse: block fully loaded
- blk_release  in  1  consumer has finished the block
- rd_req  in  1  read request strobe
- rpsel  in  2  read mode
- bank  in  2  read bank
- row  in  2  read row
- col  in  28  read column
- rd_vld  out  1  read response valid
- rd_data  out  POY*DW  response pixels; lane i = bits [i*DW +: DW]
- rd_err  out  1  response is an error (qualified by rd_vld)

Function
REQ-003 SHALL store POY x NROW x NCOL pixels of DW bits in flops; storage SHALL NOT be reset.
REQ-004 SHALL implement FSM {FILL, READY}; reset state SHALL be FILL.
REQ-005 In FILL, wr_rdy SHALL be 1; in READY, wr_rdy SHALL be 0.
REQ-006 Accepted write (wr_en & wr_rdy) with wr_bank<POY, wr_row<NROW, wr_col<NCOL SHALL update the addressed pixel at the next clk edge; out-of-range writes SHALL be dropped and not counted.
REQ-007 fill_cnt, width clog2(POY*NROW*NCOL+1), SHALL count accepted in-range writes regardless of address repetition.
REQ-008 When an accepted write brings fill_cnt to POY*NROW*NCOL, FSM SHALL go FILL->READY next cycle, and blkend SHALL be 1 for exactly that first READY cycle.
REQ-009 In READY, blk_release=1 SHALL move FSM to FILL next cycle and clear fill_cnt; blk_release in FILL SHALL be ignored.
REQ-010 Read latency SHALL be exactly 3 cycles: rd_req at edge N yields rd_vld=1 during the cycle following edge N+3; one response per request; back-to-back requests every cycle SHALL be supported.
REQ-011 Request fields (rpsel, bank, row, col) and the FSM state SHALL be sampled at the rd_req edge; later changes SHALL NOT affect that response.
REQ-012 rpsel=2'b00 (broadcast): lane i SHALL carry pixel (bank i, row, col) for i=0..POY-1; bank input ignored.
REQ-013 rpsel=2'b01 (single): lane 0 SHALL carry pixel (bank, row, col); other lanes SHALL be 0.
REQ-014 rd_err SHALL be 1 and rd_data SHALL be 0 when any of the following holds at sampling:
- rpsel is 2'b10 or 2'b11
- FSM is in FILL
- row>=NROW
- col>=NCOL
- rpsel=01 and bank>=POY
REQ-015 rd_req and blk_release in the same READY cycle: read SHALL be served as READY (valid data).
REQ-016 When rd_vld=0, rd_data and rd_err SHALL be 0.

Reset
REQ-017 rst_n=0 at an edge SHALL force state=FILL, fill_cnt=0, and flush all read pipeline stages.
REQ-018 Outputs after reset SHALL be: blkend=0, rd_vld=0, rd_err=0, rd_data=0, wr_rdy=1.
REQ-019 Reset during READY or with reads in flight SHALL drop the pending responses; no rd_vld SHALL appear for them.

Verification
REQ-020 Fill test: write all 192 pixels with value bank*64+row*16+col -> blkend pulses exactly once, one cycle after the 192nd write; wr_rdy=0 thereafter.
REQ-021 Broadcast read: rpsel=00, row=1, col=5 at edge N -> rd_vld at N+3 with lanes {0x15, 0x55, 0x95}, rd_err=0.
REQ-022 Streaming: single reads (rpsel=01) on 16 consecutive cycles sweeping col 0..15 at bank=2, row=3 -> 16 consecutive rd_vld cycles with lane 0 = 0xB0..0xBF in order.
REQ-023 Error cases, each returning rd_err=1, rd_data=0 at latency 3:
- read in FILL
- rpsel=10
- col=16
- bank=3 with rpsel=01
REQ-024 Release/reset: blk_release with a simultaneous read -> read valid; next state FILL; 192 further writes needed for the next blkend. rst_n low with 2 reads in flight -> no rd_vld; fill_cnt=0.

Source files
------------

// File: rtl/ibuf_responder.sv
// ibuf_responder: banked pixel buffer that fills once per block, then serves fixed-latency reads until released.
module ibuf_responder #(
    parameter int POY  = 3,
    parameter int NROW = 4,
    parameter int NCOL = 16,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    output logic              wr_rdy,
    input  logic [1:0]        wr_bank,
    input  logic [1:0]        wr_row,
    input  logic [27:0]       wr_col,
    input  logic [DW-1:0]     wr_data,
    output logic              blkend,
    input  logic              blk_release,
    input  logic              rd_req,
    input  logic [1:0]        rpsel,
    input  logic [1:0]        bank,
    input  logic [1:0]        row,
    input  logic [27:0]       col,
    output logic              rd_vld,
    output logic [POY*DW-1:0] rd_data,
    output logic              rd_err
);
    localparam int TOTAL = POY * NROW * NCOL;
    localparam int FW    = $clog2(TOTAL + 1);
    localparam int BW    = $clog2(POY);
    localparam int RW    = $clog2(NROW);
    localparam int CW    = $clog2(NCOL);

    typedef enum logic {FILL, READY} state_t;

    state_t              state, state_nx;
    logic [FW-1:0]       fill_cnt;
    logic [DW-1:0]       mem [POY][NROW][NCOL];
    logic                wr_hit, rd_bad;
    logic [POY*DW-1:0]   lanes;
    logic [3:0]          p_vld, p_err;
    logic [POY*DW-1:0]   p_data [4];

    assign wr_rdy  = (state == FILL);
    assign wr_hit  = wr_en & wr_rdy & ({1'b0, wr_bank} < 3'(POY)) & ({1'b0, wr_row} < 3'(NROW))
                     & (wr_col < 28'(NCOL));
    assign rd_bad  = rpsel[1] | (state == FILL) | ({1'b0, row} >= 3'(NROW)) | (col >= 28'(NCOL))
                     | ((rpsel == 2'b01) & ({1'b0, bank} >= 3'(POY)));
    assign rd_vld  = p_vld[3];
    assign rd_err  = p_err[3];
    assign rd_data = p_data[3];

    always_comb begin
        state_nx = state;
        if (state == FILL)
            state_nx = (wr_hit && fill_cnt == FW'(TOTAL - 1)) ? READY : FILL;
        else
            state_nx = blk_release ? FILL : READY;
    end

    always_comb begin
        lanes = '0;
        for (int i = 0; i < POY; i++)
            lanes[i*DW +: DW] = (rpsel == 2'b00) ? mem[i][row[RW-1:0]][col[CW-1:0]] : '0;
        if (rpsel == 2'b01)
            lanes[DW-1:0] = mem[bank[BW-1:0]][row[RW-1:0]][col[CW-1:0]];
    end

    // pixel storage is deliberately left unreset
    always_ff @(posedge clk)
        if (wr_hit)
            mem[wr_bank[BW-1:0]][wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;

    // the request is fully resolved at its sampling edge, then just delayed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            fill_cnt <= '0;
            blkend   <= 1'b0;
            p_vld    <= '0;
            p_err    <= '0;
            for (int i = 0; i < 4; i++) p_data[i] <= '0;
        end else begin
            state    <= state_nx;
            blkend   <= (state == FILL) && (state_nx == READY);
            fill_cnt <= (state == READY && blk_release) ? '0 : fill_cnt + FW'(wr_hit);
            p_vld    <= {p_vld[2:0], rd_req};
            p_err    <= {p_err[2:0], rd_req & rd_bad};
            p_data[0] <= (rd_req && !rd_bad) ? lanes : '0;
            for (int i = 1; i < 4; i++) p_data[i] <= p_data[i-1];
        end
    end
endmodule

// File: tb/tb_ibuf_responder.sv
// tb_ibuf_responder: directed vectors with hand-computed expectations for ibuf_responder.
module tb_ibuf_responder;
    logic        clk = 0, rst_n = 0;
    logic        wr_en = 0, wr_rdy;
    logic [1:0]  wr_bank = 0, wr_row = 0;
    logic [27:0] wr_col = 0;
    logic [7:0]  wr_data = 0;
    logic        blkend, blk_release = 0, rd_req = 0;
    logic [1:0]  rpsel = 0, bank = 0, row = 0;
    logic [27:0] col = 0;
    logic        rd_vld, rd_err;
    logic [23:0] rd_data;
    int          n_vec = 0, n_bad = 0, n_blkend = 0;

    ibuf_responder dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_rdy(wr_rdy), .wr_bank(wr_bank),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .blkend(blkend),
        .blk_release(blk_release), .rd_req(rd_req), .rpsel(rpsel), .bank(bank), .row(row),
        .col(col), .rd_vld(rd_vld), .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (blkend) n_blkend++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pixel index idx maps to bank idx/64, row (idx/16)%4, col idx%16 and its value is idx itself
    task automatic fill(input int s, input int n);
        wr_en = 1;
        for (int idx = s; idx < s + n; idx++) begin
            wr_bank = 2'(idx / 64);
            wr_row  = 2'((idx / 16) % 4);
            wr_col  = 28'(idx % 16);
            wr_data = 8'(idx);
            @(negedge clk);
        end
        wr_en = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] ps, input logic [1:0] b,
                          input logic [1:0] r, input logic [27:0] c, input logic rel,
                          input logic exp_err, input logic [23:0] exp_data);
        rd_req = 1; rpsel = ps; bank = b; row = r; col = c; blk_release = rel;
        @(negedge clk);
        rd_req = 0; blk_release = 0; rpsel = ~ps; bank = ~b; row = ~r; col = c + 28'd3;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early"}, rd_vld, 0);
        @(negedge clk);
        check({tag, "_vld"}, rd_vld, 1);
        check({tag, "_err"}, rd_err, exp_err);
        check({tag, "_data"}, rd_data, exp_data);
        @(negedge clk);
        check({tag, "_once"}, rd_vld, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_blkend", blkend, 0);
        check("rst_vld", rd_vld, 0);
        check("rst_err", rd_err, 0);
        check("rst_data", rd_data, 0);
        check("rst_wrrdy", wr_rdy, 1);

        rd_chk("err_fill", 2'b00, 0, 1, 5, 0, 1, 0);

        wr_en = 1; wr_bank = 3; wr_col = 0; wr_data = 8'h11;
        @(negedge clk);
        wr_bank = 0; wr_col = 16;
        @(negedge clk);
        wr_en = 0;

        fill(0, 191);
        check("pre_blkend", blkend, 0);
        check("pre_wrrdy", wr_rdy, 1);
        fill(191, 1);
        check("blkend_hi", blkend, 1);
        check("ready_wrrdy", wr_rdy, 0);
        @(negedge clk);
        check("blkend_lo", blkend, 0);
        check("blkend_cnt1", n_blkend, 1);

        wr_en = 1; wr_bank = 0; wr_row = 1; wr_col = 5; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 0;

        rd_chk("bcast", 2'b00, 3, 1, 5, 0, 0, 24'h955515);
        rd_chk("single", 2'b01, 1, 2, 15, 0, 0, 24'h00006F);
        rd_chk("err_ps10", 2'b10, 0, 1, 5, 0, 1, 0);
        rd_chk("err_ps11", 2'b11, 0, 1, 5, 0, 1, 0);
        rd_chk("err_col16", 2'b00, 0, 1, 16, 0, 1, 0);
        rd_chk("err_bank3", 2'b01, 3, 1, 5, 0, 1, 0);

        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    rd_req = 1; rpsel = 2'b01; bank = 2; row = 3; col = 28'(k);
                    @(negedge clk);
                end
                rd_req = 0;
            end
            begin
                repeat (4) @(negedge clk);
                for (int k = 0; k < 16; k++) begin
                    check($sformatf("strm_vld%0d", k), rd_vld, 1);
                    check($sformatf("strm_data%0d", k), rd_data, 24'hB0 + 24'(k));
                    @(negedge clk);
                end
                check("strm_end", rd_vld, 0);
            end
        join

        rd_chk("rel_rd", 2'b01, 0, 3, 10, 1, 0, 24'h00003A);
        check("rel_wrrdy", wr_rdy, 1);
        fill(0, 191);
        check("refill_pre", blkend, 0);
        check("refill_wrrdy", wr_rdy, 1);
        fill(191, 1);
        check("refill_blkend", blkend, 1);
        @(negedge clk);
        check("blkend_cnt2", n_blkend, 2);

        rd_req = 1; rpsel = 2'b01; bank = 2; row = 3; col = 1;
        @(negedge clk);
        col = 2;
        @(negedge clk);
        rd_req = 0; rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("flush_vld%0d", k), rd_vld, 0);
            @(negedge clk);
        end
        check("flush_cnt", dut.fill_cnt, 0);
        check("flush_wrrdy", wr_rdy, 1);
        check("flush_blkend", blkend, 0);
        rd_chk("err_after_rst", 2'b01, 2, 3, 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
